// File: rtl/ours_axi4_pkg.sv
// R payload field layout shared by the R-channel buffering blocks.
// Offsets are bit indices into the packed R payload {rdata, rid, rresp, rlast}.
package ours_axi4_pkg;

  localparam int unsigned RLAST       = 0;
  localparam int unsigned RRESP       = 1;
  localparam int unsigned RRESP_WIDTH = 2;
  localparam int unsigned RID         = RRESP + RRESP_WIDTH;

endpackage

// File: rtl/ours_r_beat_mem.sv
// Beat storage for the R burst buffer: Depth x Width flop array.
// Ports:
//   clk_i    clock
//   we_i     write enable, stores wdata_i at waddr_i on the rising edge
//   waddr_i  write address
//   wdata_i  write data
//   raddr_i  read address (asynchronous read)
//   rdata_o  read data
module ours_r_beat_mem #(
  parameter int unsigned Depth = 16,
  parameter int unsigned Width = 64,
  parameter int unsigned AddrW = $clog2(Depth)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AddrW-1:0] waddr_i,
  input  logic [Width-1:0] wdata_i,
  input  logic [AddrW-1:0] raddr_i,
  output logic [Width-1:0] rdata_o
);

  logic [Width-1:0] mem_q [Depth];

  // No reset: contents are only ever read behind a valid occupancy count.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/ours_axi4_r_burst_buf.sv
// Per-source R-channel burst accumulator placed in front of an R arbiter input.
// Beats are held until the whole burst (rlast) is stored, then released back to back,
// so a slow source cannot keep the arbiter's rlast lock while dribbling beats. A burst
// longer than DEPTH switches to cut-through once storage fills, so it never deadlocks.
// Ports:
//   clk          clock
//   rst          synchronous reset, active-high
//   slave_rvld   beat valid from the source
//   slave_r      beat payload (rlast at RLAST_POSITION)
//   slave_rrdy   beat accepted when slave_rvld & slave_rrdy
//   master_rvld  beat valid toward the arbiter
//   master_r     beat payload toward the arbiter
//   master_rrdy  arbiter ready
//   clk_en       request for the upstream clock gate
module ours_axi4_r_burst_buf
  import ours_axi4_pkg::*;
#(
  parameter int unsigned BACKEND_DOMAIN = 0,
  parameter int unsigned WIDTH          = 64,
  parameter int unsigned RLAST_POSITION = RLAST,
  parameter int unsigned DEPTH          = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             slave_rvld,
  input  logic [WIDTH-1:0] slave_r,
  output logic             slave_rrdy,
  output logic             master_rvld,
  output logic [WIDTH-1:0] master_r,
  input  logic             master_rrdy,
  output logic             clk_en
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] cmpl_cnt_q, cmpl_cnt_d;
  logic          passthru_q, passthru_d;

  logic full, empty, push, pop, rlast_in, rlast_out;

  // Domain tag only matters to the clock-gate netlist, not to this logic.
  logic unused_backend_domain;
  assign unused_backend_domain = ^BACKEND_DOMAIN;

  assign full      = (cnt_q == CW'(DEPTH));
  assign empty     = (cnt_q == '0);
  assign rlast_in  = slave_r[RLAST_POSITION];
  assign rlast_out = master_r[RLAST_POSITION];

  // Ready depends only on occupancy and reset, never on master_rrdy.
  assign slave_rrdy  = ~full & ~rst;
  // Every term can only fall through a pop, so valid is stable until taken.
  assign master_rvld = ~empty & ((cmpl_cnt_q != '0) | passthru_q | full);
  assign push        = slave_rvld & slave_rrdy;
  assign pop         = master_rvld & master_rrdy;
  assign clk_en      = rst | slave_rvld | ~empty;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    cmpl_cnt_d = cmpl_cnt_q;
    passthru_d = passthru_q;
    cnt_d      = cnt_q + CW'(push) - CW'(pop);

    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);

    unique case ({push & rlast_in, pop & rlast_out})
      2'b10:   cmpl_cnt_d = cmpl_cnt_q + CW'(1);
      2'b01:   cmpl_cnt_d = cmpl_cnt_q - CW'(1);
      default: cmpl_cnt_d = cmpl_cnt_q;
    endcase

    // A pop with no complete burst stored can only come from a full buffer:
    // stream the rest of this burst until its rlast leaves.
    if (pop) begin
      if (rlast_out) begin
        passthru_d = 1'b0;
      end else if (cmpl_cnt_q == '0) begin
        passthru_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      cmpl_cnt_q <= '0;
      passthru_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      cmpl_cnt_q <= cmpl_cnt_d;
      passthru_q <= passthru_d;
    end
  end

  ours_r_beat_mem #(
    .Depth (DEPTH),
    .Width (WIDTH)
  ) u_mem (
    .clk_i   (clk),
    .we_i    (push),
    .waddr_i (wr_ptr_q),
    .wdata_i (slave_r),
    .raddr_i (rd_ptr_q),
    .rdata_o (master_r)
  );

endmodule

// File: tb/tb_ours_axi4_r_burst_buf.sv
// Self-checking bench for ours_axi4_r_burst_buf against a queue-based reference model.
module tb_ours_axi4_r_burst_buf;

  localparam int unsigned W  = 64;
  localparam int unsigned D  = 16;
  localparam int unsigned RL = 0;

  logic         clk = 1'b0;
  logic         rst;
  logic         slave_rvld;
  logic [W-1:0] slave_r;
  logic         slave_rrdy;
  logic         master_rvld;
  logic [W-1:0] master_r;
  logic         master_rrdy;
  logic         clk_en;

  always #5 clk = ~clk;

  ours_axi4_r_burst_buf #(
    .BACKEND_DOMAIN (0),
    .WIDTH          (W),
    .RLAST_POSITION (RL),
    .DEPTH          (D)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .slave_rvld  (slave_rvld),
    .slave_r     (slave_r),
    .slave_rrdy  (slave_rrdy),
    .master_rvld (master_rvld),
    .master_r    (master_r),
    .master_rrdy (master_rrdy),
    .clk_en      (clk_en)
  );

  // Reference model: stored beats in arrival order, plus the cut-through flag.
  logic [W-1:0] q[$];
  logic [W-1:0] pend[$];
  bit           pt;
  int unsigned  n_cmp;
  int unsigned  n_err;
  int unsigned  total_push;

  function automatic logic [W-1:0] mk(input logic last);
    logic [W-1:0] v;
    v = {$urandom(), $urandom()};
    v[RL] = last;
    return v;
  endfunction

  function automatic int unsigned n_complete();
    int unsigned n = 0;
    foreach (q[i]) if (q[i][RL]) n++;
    return n;
  endfunction

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, check outputs at the falling edge, then advance the model.
  task automatic cyc(input logic vld, input logic [W-1:0] d, input logic rrdy, output bit acc);
    bit e_rrdy, e_vld, pop;
    slave_rvld  = vld;
    slave_r     = d;
    master_rrdy = rrdy;
    @(negedge clk);
    e_rrdy = !rst && (q.size() < D);
    e_vld  = !rst && (q.size() > 0) && (n_complete() > 0 || pt || q.size() == D);
    chk("slave_rrdy", W'(slave_rrdy), W'(e_rrdy));
    chk("master_rvld", W'(master_rvld), W'(e_vld));
    chk("clk_en", W'(clk_en), W'(rst | vld | (q.size() != 0)));
    if (e_vld) chk("master_r", master_r, q[0]);
    acc = vld && e_rrdy;
    pop = e_vld && rrdy;
    @(posedge clk);
    #1;
    if (rst) begin
      q.delete();
      pt = 0;
    end else begin
      if (pop) begin
        if (q[0][RL]) pt = 0;
        else if (n_complete() == 0) pt = 1;
        void'(q.pop_front());
      end
      if (acc) begin
        q.push_back(d);
        total_push++;
      end
    end
  endtask

  // Offer pending beats with the given valid/ready probabilities (percent) for up to n cycles.
  task automatic run_pend(input int unsigned n, input int unsigned pv, input int unsigned pr);
    bit acc, v;
    for (int k = 0; k < n; k++) begin
      v = (pend.size() > 0) && ($urandom_range(99) < pv);
      cyc(v, v ? pend[0] : '0, $urandom_range(99) < pr, acc);
      if (acc) void'(pend.pop_front());
      if (pend.size() == 0 && q.size() == 0) break;
    end
  endtask

  initial begin
    bit acc;
    int unsigned len;
    n_cmp = 0;
    n_err = 0;
    total_push = 0;
    pt = 0;
    rst = 1'b1;
    slave_rvld = 1'b1;
    slave_r = '0;
    master_rrdy = 1'b0;
    @(posedge clk);
    #1;

    // Reset held with a valid source: nothing accepted, nothing offered.
    for (int k = 0; k < 3; k++) cyc(1'b1, mk(0), 1'b1, acc);
    rst = 1'b0;
    cyc(1'b0, '0, 1'b1, acc);

    // 4-beat burst with gaps: released only once rlast is stored.
    for (int k = 0; k < 16; k++) begin
      bit v = (k == 2 || k == 5 || k == 6 || k == 9);
      cyc(v, mk(k == 9), 1'b1, acc);
    end

    // 20-beat burst into 16 entries: fills, then cuts through.
    for (int i = 0; i < 20; i++) pend.push_back(mk(i == 19));
    run_pend(200, 100, 100);
    chk("burst20_drained", W'(pend.size()), W'(0));
    for (int k = 0; k < 4; k++) cyc(1'b0, '0, 1'b1, acc);

    // Back-pressure: complete 3-beat burst then a long partial one, ready low.
    for (int i = 0; i < 3; i++) pend.push_back(mk(i == 2));
    for (int i = 0; i < 15; i++) pend.push_back(mk(i == 14));
    for (int k = 0; k < 20; k++) begin
      cyc(pend.size() > 0, pend.size() > 0 ? pend[0] : '0, 1'b0, acc);
      if (acc) void'(pend.pop_front());
    end
    chk("backpressure_accepted", W'(18 - pend.size()), W'(D));
    run_pend(200, 100, 100);
    for (int k = 0; k < 4; k++) cyc(1'b0, '0, 1'b1, acc);

    // Pop of A's rlast coincides with push of B's rlast.
    begin
      logic [W-1:0] a0, a1, b0, b1;
      a0 = mk(0); a1 = mk(1); b0 = mk(0); b1 = mk(1);
      cyc(1'b1, a0, 1'b0, acc);
      cyc(1'b1, a1, 1'b0, acc);
      cyc(1'b1, b0, 1'b0, acc);
      cyc(1'b0, '0, 1'b1, acc);
      cyc(1'b1, b1, 1'b1, acc);
      for (int k = 0; k < 4; k++) cyc(1'b0, '0, 1'b1, acc);
    end

    // Random bursts, mostly short, occasionally longer than storage.
    total_push = 0;
    for (int b = 0; b < 40; b++) begin
      len = ($urandom_range(9) == 0) ? $urandom_range(24, 17) : $urandom_range(4, 1);
      for (int i = 0; i < len; i++) pend.push_back(mk(i == len - 1));
    end
    run_pend(20000, 70, 60);
    for (int k = 0; k < 60 && q.size() > 0; k++) cyc(1'b0, '0, 1'b1, acc);
    chk("random_all_pushed", W'(pend.size()), W'(0));
    chk("random_ptr_wrapped_twice", W'(total_push >= 2 * D), W'(1));
    cyc(1'b0, '0, 1'b1, acc);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
